// File: rtl/solution_streamer_if.sv
// Output stream bus of the solution streamer: one tile word per valid/ready
// handshake, carrying the decoded digit plus its row/column tags.
// Default grid order comes from the GRID_ORD macro (3 when not defined).
`ifndef GRID_ORD
`define GRID_ORD 3
`endif

interface solution_streamer_if #(
  parameter int ORD = `GRID_ORD
) ();
  localparam int LEN = ORD * ORD;
  localparam int VW  = $clog2(LEN + 1);
  localparam int IW  = $clog2(LEN);

  // Handshake: a word transfers on every rising clock edge where out_valid
  // and out_ready are both 1. While out_valid=1 and out_ready=0 the master
  // holds every payload field stable. out_valid never depends on out_ready.
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_value;
  logic [IW-1:0] out_row;
  logic [IW-1:0] out_col;
  logic          out_last;

  modport master (
    output out_valid, out_value, out_row, out_col, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_value, out_row, out_col, out_last,
    output out_ready
  );
endinterface

// File: rtl/solution_streamer.sv
// solution_streamer: snapshots the tile grid on done_success and streams the
// tiles row-major as digits with row/col tags; latches done_failure as a
// sticky flag. Optional row-consistency checker: SOLUTION_CHECK_EN.
// Default grid order comes from the GRID_ORD macro (3 when not defined).
`ifndef GRID_ORD
`define GRID_ORD 3
`endif

module solution_streamer #(
  parameter int ORD = `GRID_ORD
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             done_success,
  input  logic                             done_failure,
  input  logic [ORD*ORD*ORD*ORD*ORD*ORD-1:0] values,
  solution_streamer_if.master              strm,
  output logic                             busy,
  output logic                             failed,
  output logic                             check_error,
  output logic [1:0]                       state_dbg
);
  localparam int LEN  = ORD * ORD;
  localparam int AREA = LEN * LEN;
  localparam int VW   = $clog2(LEN + 1);
  localparam int IW   = $clog2(LEN);
  localparam int XW   = $clog2(AREA);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [AREA*LEN-1:0] r_snap;
  logic [XW-1:0]       r_idx;
  logic [IW-1:0]       r_row;
  logic [IW-1:0]       r_col;
  logic                r_failed;
  logic                w_valid;
  logic                w_fire;
  logic                w_at_last;
  logic                w_capture;
  logic [LEN-1:0]      w_tile;
  logic [VW-1:0]       w_value;
  int                  w_cnt;

  assign w_fire    = w_valid & strm.out_ready;
  assign w_at_last = (r_idx == XW'(AREA - 1));
  assign w_capture = (r_state == S_IDLE) & done_success;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: success beats failure in IDLE; DRAIN waits for both done
  // levels to drop so a held level cannot retrigger a capture.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (done_success)      w_next = S_STREAM;
        else if (done_failure) w_next = S_DRAIN;
      end
      S_STREAM: if (w_fire && w_at_last) w_next = S_DRAIN;
      S_DRAIN:  if (!done_success && !done_failure) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM outputs: the stream is valid exactly while in STREAM.
  always_comb begin
    w_valid   = (r_state == S_STREAM);
    busy      = w_valid;
    state_dbg = r_state;
  end

  // Snapshot, tile index with separate row/col counters, and failure flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_snap   <= '0;
      r_idx    <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_failed <= 1'b0;
    end else if (w_capture) begin
      r_snap   <= values;
      r_idx    <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_failed <= 1'b0;
    end else if (r_state == S_IDLE && done_failure) begin
      r_failed <= 1'b1;
    end else if (w_fire && !w_at_last) begin
      r_idx <= r_idx + XW'(1);
      if (r_col == IW'(LEN - 1)) begin
        r_col <= '0;
        r_row <= r_row + IW'(1);
      end else begin
        r_col <= r_col + IW'(1);
      end
    end
  end

  // One-hot decode of the current tile: digit k+1 for bit k, 0 otherwise.
  always_comb begin
    w_tile  = r_snap[r_idx*LEN +: LEN];
    w_value = '0;
    w_cnt   = 0;
    for (int k = 0; k < LEN; k++) begin
      if (w_tile[k]) begin
        w_cnt   = w_cnt + 1;
        w_value = VW'(k + 1);
      end
    end
    if (w_cnt != 1) w_value = '0;
  end

  // Stream payload, forced to zero when no word is presented.
  always_comb begin
    strm.out_valid = w_valid;
    strm.out_value = w_valid ? w_value : '0;
    strm.out_row   = w_valid ? r_row : '0;
    strm.out_col   = w_valid ? r_col : '0;
    strm.out_last  = w_valid & w_at_last;
  end

  assign failed = r_failed;

`ifdef SOLUTION_CHECK_EN
  logic [LEN-1:0] r_acc;
  logic           r_chk;

  // Row occupancy accumulator: flags non-one-hot tiles and repeated digits
  // within a row; cleared when the column wraps back to 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
      r_chk <= 1'b0;
    end else if (w_capture) begin
      r_acc <= '0;
      r_chk <= 1'b0;
    end else if (w_fire) begin
      if ((w_value == '0) || ((w_tile & r_acc) != '0)) r_chk <= 1'b1;
      if (r_col == IW'(LEN - 1)) r_acc <= '0;
      else                       r_acc <= r_acc | w_tile;
    end
  end

  assign check_error = r_chk;
`else
  assign check_error = 1'b0;
`endif
endmodule

// File: tb/tb_solution_streamer.sv
// Bench for solution_streamer at ORD=2 (4x4 grid): directed scenarios with
// literal expectations, plus a queue-based model checked every negedge.
module tb_solution_streamer;
  localparam int ORD  = 2;
  localparam int LEN  = 4;
  localparam int AREA = 16;
  localparam int W    = 8;   // {last, row[1:0], col[1:0], value[2:0]}
`ifdef SOLUTION_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        done_success = 1'b0;
  logic        done_failure = 1'b0;
  logic [63:0] values = '0;
  logic        busy, failed, check_error;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  solution_streamer_if #(.ORD(ORD)) s ();

  solution_streamer #(.ORD(ORD)) dut (
    .clock        (clk),
    .reset        (reset),
    .done_success (done_success),
    .done_failure (done_failure),
    .values       (values),
    .strm         (s),
    .busy         (busy),
    .failed       (failed),
    .check_error  (check_error),
    .state_dbg    (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Digit nibbles (tile 0 in the LSB nibble) -> one-hot grid vector.
  function automatic logic [63:0] onehot_grid(input logic [63:0] digits);
    logic [63:0] g;
    g = '0;
    for (int i = 0; i < AREA; i++)
      g[i*4 +: 4] = 4'b0001 << (digits[i*4 +: 4] - 4'd1);
    return g;
  endfunction

  // ---------------- model / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  bit           err_q[$];
  bit           m_idle   = 1'b1;
  bit           m_failed = 1'b0;
  bit           m_chk    = 1'b0;

  task automatic build_expected(input logic [63:0] v);
    logic [3:0] t;
    logic [3:0] seen;
    int         dig;
    seen = '0;
    for (int i = 0; i < AREA; i++) begin
      t   = v[i*4 +: 4];
      dig = ($countones(t) == 1) ? $clog2(t) + 1 : 0;
      if (i % LEN == 0) seen = '0;
      err_q.push_back((dig == 0) || ((seen & t) != 0));
      seen = seen | t;
      exp_q.push_back({(i == AREA - 1), 2'(i / LEN), 2'(i % LEN), 3'(dig)});
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      err_q.delete();
      m_idle   <= 1'b1;
      m_failed <= 1'b0;
      m_chk    <= 1'b0;
    end else if (m_idle) begin
      if (done_success) begin
        build_expected(values);
        m_failed <= 1'b0;
        m_chk    <= 1'b0;
        m_idle   <= 1'b0;
      end else if (done_failure) begin
        m_failed <= 1'b1;
        m_idle   <= 1'b0;
      end
    end else if (exp_q.size() > 0) begin
      if (s.out_ready) begin
        if (err_q[0] && CHK) m_chk <= 1'b1;
        void'(exp_q.pop_front());
        void'(err_q.pop_front());
      end
    end else if (!done_success && !done_failure) begin
      m_idle <= 1'b1;
    end
  end

  // Compare process: every negedge outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() > 0) begin
        check("model_valid", 32'(s.out_valid), 32'd1);
        check("model_word", 32'({s.out_last, s.out_row, s.out_col, s.out_value}), 32'(exp_q[0]));
      end else begin
        check("model_no_valid", 32'(s.out_valid), 32'd0);
        check("model_no_last", 32'(s.out_last), 32'd0);
      end
      check("model_busy", 32'(busy), 32'(exp_q.size() > 0));
      check("model_failed", 32'(failed), 32'(m_failed));
      check("model_check_error", 32'(check_error), 32'(m_chk));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [63:0] v);
    values       = v;
    done_success = 1'b1;
    tick();
    done_success = 1'b0;
  endtask

  // Run with ready=1 until the last word transfers, then let DRAIN exit.
  task automatic wait_last();
    bit found;
    found = 1'b0;
    s.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (s.out_valid && s.out_last) begin
        found = 1'b1;
        tick();
        break;
      end
      tick();
    end
    check("wait_last_timeout", 32'(found), 32'd1);
    tick();
  endtask

  logic [63:0] g1, g2, g3a, g3b;
  logic [W-1:0] held;

  initial begin
    g1  = onehot_grid(64'h1234_3412_2143_4321);
    g2  = onehot_grid(64'h2143_4321_1234_3412);
    g3a = g1;
    g3a[6*4 +: 4] = 4'b0011;
    g3b = onehot_grid(64'h1234_4311_2143_4321);
    s.out_ready = 1'b0;

    // Reset state.
    #3;
    check("reset_valid", 32'(s.out_valid), 32'd0);
    check("reset_word", 32'({s.out_last, s.out_row, s.out_col, s.out_value}), 32'd0);
    check("reset_flags", 32'({busy, failed, check_error}), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Full stream with done_success held through the stream.
    s.out_ready  = 1'b1;
    values       = g1;
    done_success = 1'b1;
    tick();
    check("first_valid", 32'(s.out_valid), 32'd1);
    check("first_word", 32'({s.out_value, s.out_row, s.out_col}), 32'({3'd1, 2'd0, 2'd0}));
    for (int i = 0; i < 15; i++) tick();
    check("word16", 32'({s.out_last, s.out_row, s.out_col, s.out_value}), 32'({1'b1, 2'd3, 2'd3, 3'd1}));
    tick();
    for (int i = 0; i < 3; i++) begin
      check("drain_hold", 32'(state_dbg), 32'd2);
      tick();
    end
    done_success = 1'b0;
    tick();
    check("drain_exit", 32'(state_dbg), 32'd0);

    // Backpressure and post-capture grid changes.
    capture(g2);
    values = ~g2;
    for (int i = 0; i < 5; i++) tick();      // words 1..5 accepted
    s.out_ready = 1'b0;
    held = {s.out_last, s.out_row, s.out_col, s.out_value};
    check("bp_word6", 32'(held), 32'({1'b0, 2'd1, 2'd1, 3'd3}));
    tick();
    check("bp_hold1", 32'({s.out_last, s.out_row, s.out_col, s.out_value}), 32'(held));
    tick();
    s.out_ready = 1'b1;
    check("bp_hold2", 32'({s.out_last, s.out_row, s.out_col, s.out_value}), 32'(held));
    wait_last();

    // Failure pulse, later capture clears it.
    done_failure = 1'b1;
    tick();
    done_failure = 1'b0;
    check("failed_rise", 32'(failed), 32'd1);
    check("failed_no_stream", 32'(s.out_valid), 32'd0);
    tick();
    tick();
    check("failed_sticky", 32'({failed, s.out_valid}), 32'({1'b1, 1'b0}));
    capture(g1);
    check("failed_cleared", 32'({failed, s.out_valid}), 32'({1'b0, 1'b1}));
    wait_last();

    // Both done inputs together: success wins.
    values       = g2;
    done_success = 1'b1;
    done_failure = 1'b1;
    tick();
    done_success = 1'b0;
    done_failure = 1'b0;
    check("both_stream", 32'({s.out_valid, failed, s.out_value}), 32'({1'b1, 1'b0, 3'd2}));
    wait_last();

    // Non-one-hot tile (1,2).
    capture(g3a);
    for (int i = 0; i < 6; i++) tick();
    check("bad_tile_word", 32'({s.out_row, s.out_col, s.out_value}), 32'({2'd1, 2'd2, 3'd0}));
    check("bad_tile_pre", 32'(check_error), 32'd0);
    tick();
    check("bad_tile_err", 32'(check_error), 32'(CHK));
    wait_last();

    // Duplicate digit in row 2.
    capture(g3b);
    check("dup_cleared", 32'(check_error), 32'd0);
    for (int i = 0; i < 9; i++) tick();
    check("dup_word10", 32'({s.out_row, s.out_col, s.out_value}), 32'({2'd2, 2'd1, 3'd1}));
    check("dup_pre", 32'(check_error), 32'd0);
    tick();
    check("dup_err", 32'(check_error), 32'(CHK));
    wait_last();

    // Reset mid-stream at word 7, then restart.
    capture(g2);
    for (int i = 0; i < 6; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_valid", 32'(s.out_valid), 32'd0);
    check("rst_mid_word", 32'({s.out_last, s.out_row, s.out_col, s.out_value}), 32'd0);
    check("rst_mid_flags", 32'({busy, failed, check_error}), 32'd0);
    check("rst_mid_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    capture(g2);
    check("restart_word", 32'({s.out_valid, s.out_row, s.out_col, s.out_value}), 32'({1'b1, 2'd0, 2'd0, 3'd2}));
    wait_last();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
